// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 32x32 register file: an optional init sweep, then
// core/debug arbitration with a starvation guard on the debug path.
// Optional feature macro: REGARB_INIT_SWEEP_EN (sweep all registers after reset).
module regfile_write_arbiter #(
    parameter int unsigned       NUM_REGS     = 32,
    parameter int unsigned       ADDR_W       = 5,
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       STARVE_LIMIT = 4,
    parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_valid,
    output logic              core_ready,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_data,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              init_done,
    output logic              dbg_forced
);

    typedef enum logic {StInit, StRun} state_e;

    localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);
    localparam logic [3:0] StarveMax = 4'd15;

`ifdef REGARB_INIT_SWEEP_EN
    localparam state_e ResetState = StInit;
    localparam logic   ResetDone  = 1'b0;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
`else
    localparam state_e ResetState = StRun;
    localparam logic   ResetDone  = 1'b1;
    // Sweep configuration has no effect without the init sweep.
    logic unused_cfg;
    assign unused_cfg = ^{INIT_VALUE, NUM_REGS};
`endif

    state_e            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              forced_q, forced_d;
    logic              force_dbg, core_gnt, dbg_gnt;

    // Ready/grant decode; readies never look at the requester's own valid.
    always_comb begin
        force_dbg  = (state_q == StRun) && (starve_q >= StarveLim);
        core_ready = (state_q == StRun) && !force_dbg;
        dbg_ready  = (state_q == StRun) && (force_dbg || !core_valid);
        core_gnt   = core_valid && core_ready;
        dbg_gnt    = dbg_valid && dbg_ready && !core_gnt;
    end

    // Next-state: sweep issue in INIT, granted write issue in RUN.
    always_comb begin
        state_d  = state_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = done_q;
        forced_d = 1'b0;
`ifdef REGARB_INIT_SWEEP_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            StInit: begin
`ifdef REGARB_INIT_SWEEP_EN
                we_d   = 1'b1;
                addr_d = cnt_q;
                data_d = INIT_VALUE;
                cnt_d  = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d = StRun;
                    done_d  = 1'b1;
                end
`else
                state_d = StRun;
                done_d  = 1'b1;
`endif
            end
            StRun: begin
                if (core_gnt) begin
                    // x0 writes complete the handshake but never assert WE.
                    we_d   = (core_addr != '0);
                    addr_d = core_addr;
                    data_d = core_data;
                end else if (dbg_gnt) begin
                    we_d     = (dbg_addr != '0);
                    addr_d   = dbg_addr;
                    data_d   = dbg_data;
                    forced_d = force_dbg;
                end
            end
        endcase
    end

    // Starvation counter: counts stalled debug-valid cycles, saturating.
    always_comb begin
        starve_d = starve_q;
        if (dbg_gnt || !dbg_valid) begin
            starve_d = '0;
        end else if (starve_q != StarveMax) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ResetState;
            starve_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= ResetDone;
            forced_q <= 1'b0;
`ifdef REGARB_INIT_SWEEP_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
            forced_q <= forced_d;
`ifdef REGARB_INIT_SWEEP_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign rf_we      = we_q;
    assign rf_waddr   = addr_q;
    assign rf_wdata   = data_q;
    assign init_done  = done_q;
    assign dbg_forced = forced_q;

endmodule
